// File: rtl/neuron_layer_teacher.sv
// neuron_layer_teacher
// Training initiator for one learning layer. Stores DEPTH input/target samples,
// presents them to the layer one at a time, scores the layer outputs against the
// targets and pulses learn for every sample with mis-scored outputs. Epochs repeat
// until one finishes with zero errors or the epoch limit is reached.
// zero2one_t elements are ZW-bit unsigned fractions carried as packed vectors.
module neuron_layer_teacher #(
  parameter int N_IN       = 16,
  parameter int N_OUT      = 50,
  parameter int DEPTH      = 8,
  parameter int SETTLE     = 2,
  parameter int TOL        = 0,
  parameter int EPOCHS_MAX = 255,
  parameter int ZW         = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NW = $clog2(DEPTH + 1),
  localparam int EW = $clog2(DEPTH * N_OUT + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_we,
  input  logic [AW-1:0]              load_addr,
  input  logic [N_IN-1:0][ZW-1:0]    load_in,
  input  logic [N_OUT-1:0][ZW-1:0]   load_expected,
  input  logic [NW-1:0]              num_samples,
  input  logic                       start,
  output logic                       layer_valid,
  output logic                       layer_learn,
  output logic [N_IN-1:0][ZW-1:0]    layer_in,
  output logic [N_OUT-1:0][ZW-1:0]   layer_expected,
  input  logic [N_OUT-1:0][ZW-1:0]   layer_out,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [7:0]                 epoch_count,
  output logic [EW-1:0]              err_count
);

  localparam int SW = $clog2(N_OUT + 1);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ZW-1:0] TOL_V  = ZW'(TOL);
  localparam logic [7:0]    EMAX   = 8'(EPOCHS_MAX);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_PRESENT, S_SETTLE, S_CHECK, S_LEARN, S_NEXT, S_EPOCH_END, S_DONE
  } state_e;

  state_e                     state_q;
  logic [NW-1:0]              n_q;
  logic [AW-1:0]              idx_q;
  logic [CW-1:0]              settle_q;
  logic [7:0]                 epoch_q;
  logic [EW-1:0]              err_q;
  logic                       valid_q, learn_q, busy_q, done_q, conv_q;
  logic [N_IN-1:0][ZW-1:0]    in_q;
  logic [N_OUT-1:0][ZW-1:0]   exp_q;

  logic [N_IN-1:0][ZW-1:0]    mem_in  [DEPTH];
  logic [N_OUT-1:0][ZW-1:0]   mem_exp [DEPTH];

  logic [NW-1:0]              n_d;
  logic [AW-1:0]              idx_inc_d;
  logic [7:0]                 epoch_inc_d;
  logic                       last_d;
  logic [ZW-1:0]              diff_d;
  logic [SW-1:0]              miss_d;

  // Sample storage; the loader is locked out while a run is in progress.
  // NOTE: the sample memory is deliberately left out of reset -- it is plain storage,
  // and clearing it would cost a reset fan-out to every bit for no functional gain.
  always_ff @(posedge clock) begin
    if (load_we && !busy_q) begin
      mem_in[load_addr]  <= load_in;
      mem_exp[load_addr] <= load_expected;
    end
  end

  assign n_d         = (num_samples > NW'(DEPTH)) ? NW'(DEPTH) : num_samples;
  assign idx_inc_d   = idx_q + AW'(1);
  assign epoch_inc_d = (epoch_q == 8'hFF) ? epoch_q : epoch_q + 8'd1;
  assign last_d      = (NW'(idx_q) == n_q - NW'(1));

  // Score the current sample: count outputs whose unsigned distance to target exceeds TOL.
  // NOTE: blocking assignments here on purpose -- the loop accumulates within one
  // evaluation; every variable gets a default first so no latch is inferred.
  always_comb begin
    diff_d = '0;
    miss_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      diff_d = (layer_out[j] > exp_q[j]) ? layer_out[j] - exp_q[j] : exp_q[j] - layer_out[j];
      if (diff_d > TOL_V) miss_d = miss_d + SW'(1);
    end
  end

  // Training sequencer with registered layer strobes, vectors and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      epoch_q  <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      learn_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      conv_q   <= 1'b0;
      in_q     <= '0;
      exp_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      learn_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_LATCH;
            n_q     <= n_d;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_LATCH: begin
          idx_q   <= '0;
          epoch_q <= '0;
          err_q   <= '0;
          conv_q  <= 1'b0;
          if (n_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            conv_q  <= 1'b1;
          end else begin
            state_q <= S_PRESENT;
            valid_q <= 1'b1;
            in_q    <= mem_in[0];
            exp_q   <= mem_exp[0];
          end
        end
        S_PRESENT: begin
          state_q  <= S_SETTLE;
          settle_q <= '0;
        end
        S_SETTLE: begin
          if (settle_q == SET_LAST) state_q <= S_CHECK;
          else                      settle_q <= settle_q + CW'(1);
        end
        S_CHECK: begin
          err_q <= err_q + EW'(miss_d);
          if (miss_d != '0) begin
            state_q <= S_LEARN;
            valid_q <= 1'b1;
            learn_q <= 1'b1;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_LEARN: state_q <= S_NEXT;
        S_NEXT: begin
          if (last_d) begin
            state_q <= S_EPOCH_END;
          end else begin
            state_q <= S_PRESENT;
            idx_q   <= idx_inc_d;
            valid_q <= 1'b1;
            in_q    <= mem_in[idx_inc_d];
            exp_q   <= mem_exp[idx_inc_d];
          end
        end
        S_EPOCH_END: begin
          epoch_q <= epoch_inc_d;
          if (err_q == '0 || epoch_inc_d == EMAX) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            conv_q  <= (err_q == '0);
          end else begin
            state_q <= S_PRESENT;
            idx_q   <= '0;
            err_q   <= '0;
            valid_q <= 1'b1;
            in_q    <= mem_in[0];
            exp_q   <= mem_exp[0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign layer_valid    = valid_q;
  assign layer_learn    = learn_q;
  assign layer_in       = in_q;
  assign layer_expected = exp_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign converged      = conv_q;
  assign epoch_count    = epoch_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_neuron_layer_teacher.sv
// Directed bench for neuron_layer_teacher: a stub layer (echo / all-zero /
// converges after three epochs) drives DUT A (TOL=0); DUT B (TOL=1, 3-epoch
// limit) exercises the tolerance window with a fixed offset stub.
module tb_neuron_layer_teacher;
  localparam int N_IN = 16, N_OUT = 50, DEPTH = 8, ZW = 8;
  localparam int AW = 3, NW = 4, EW = $clog2(DEPTH * N_OUT + 1);
  typedef logic [N_IN-1:0][ZW-1:0]  vin_t;
  typedef logic [N_OUT-1:0][ZW-1:0] vout_t;
  typedef enum int {M_ECHO, M_ZERO, M_CONV3} mode_e;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A
  logic load_we = 1'b0;  logic [AW-1:0] load_addr = '0;
  vin_t load_in = '0;    vout_t load_expected = '0;
  logic [NW-1:0] num_samples = '0; logic start = 1'b0;
  logic layer_valid, layer_learn, busy, done, converged;
  vin_t layer_in; vout_t layer_expected, layer_out;
  logic [7:0] epoch_count; logic [EW-1:0] err_count;

  // DUT B
  logic load_we_b = 1'b0; logic [AW-1:0] load_addr_b = '0;
  vin_t load_in_b = '0;   vout_t load_expected_b = '0;
  logic [NW-1:0] num_samples_b = '0; logic start_b = 1'b0;
  logic layer_valid_b, layer_learn_b, busy_b, done_b, converged_b;
  vin_t layer_in_b; vout_t layer_expected_b, layer_out_b;
  logic [7:0] epoch_count_b; logic [EW-1:0] err_count_b;

  neuron_layer_teacher dut_a (
    .clock(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_in(load_in), .load_expected(load_expected), .num_samples(num_samples),
    .start(start), .layer_valid(layer_valid), .layer_learn(layer_learn),
    .layer_in(layer_in), .layer_expected(layer_expected), .layer_out(layer_out),
    .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count),
    .err_count(err_count));

  neuron_layer_teacher #(.TOL(1), .EPOCHS_MAX(3)) dut_b (
    .clock(clk), .reset(reset), .load_we(load_we_b), .load_addr(load_addr_b),
    .load_in(load_in_b), .load_expected(load_expected_b), .num_samples(num_samples_b),
    .start(start_b), .layer_valid(layer_valid_b), .layer_learn(layer_learn_b),
    .layer_in(layer_in_b), .layer_expected(layer_expected_b), .layer_out(layer_out_b),
    .busy(busy_b), .done(done_b), .converged(converged_b), .epoch_count(epoch_count_b),
    .err_count(err_count_b));

  int n_cmp = 0, n_bad = 0;
  int valid_cnt = 0, learn_cnt = 0, consec_cnt = 0, stray_cnt = 0, learn_base = 0;
  logic prev_valid = 1'b0, prev_valid_b = 1'b0;
  mode_e mode = M_ECHO;
  vout_t off_b = '0;

  // Stub layers.
  always_comb begin
    case (mode)
      M_ECHO:  layer_out = layer_expected;
      M_ZERO:  layer_out = '0;
      default: layer_out = (learn_cnt - learn_base >= 6) ? layer_expected : '0;
    endcase
  end

  always_comb begin
    layer_out_b = '0;
    for (int j = 0; j < N_OUT; j++) layer_out_b[j] = layer_expected_b[j] + off_b[j];
  end

  // Pulse monitor: sees the value each output held during the cycle just ending.
  always @(posedge clk) begin
    if (layer_valid) valid_cnt++;
    if (layer_learn) learn_cnt++;
    if (layer_valid && prev_valid) consec_cnt++;
    if (layer_valid_b && prev_valid_b) consec_cnt++;
    if (layer_learn && !layer_valid) stray_cnt++;
    if (layer_learn_b && !layer_valid_b) stray_cnt++;
    prev_valid   = layer_valid;
    prev_valid_b = layer_valid_b;
  end

  function automatic vin_t mk_in(input int k);
    vin_t r;
    for (int i = 0; i < N_IN; i++) r[i] = 8'(k * 17 + i + 1);
    return r;
  endfunction

  function automatic vout_t mk_exp(input int k);
    vout_t r;
    for (int j = 0; j < N_OUT; j++) r[j] = 8'(k * 31 + j * 5 + 1);
    return r;
  endfunction

  function automatic vout_t fill_out(input logic [7:0] v);
    vout_t r;
    for (int j = 0; j < N_OUT; j++) r[j] = v;
    return r;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_a(input int addr, input vin_t vi, input vout_t vo);
    load_we = 1'b1; load_addr = AW'(addr); load_in = vi; load_expected = vo;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Start a run on DUT A and wait (bounded) for done. poke=1: start and write
  // sample 0 while busy; poke=2: write sample 0 in the same cycle as start.
  task automatic run_a(input int n, input int budget, input int poke,
                       output int t_valid, output int t_done, output vin_t first_in);
    t_valid = -1; t_done = -1; first_in = '0;
    num_samples = NW'(n); start = 1'b1;
    if (poke == 2) begin
      load_we = 1'b1; load_addr = '0; load_in = mk_in(9); load_expected = mk_exp(9);
    end
    @(negedge clk);
    start = 1'b0; load_we = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (layer_valid && t_valid < 0) begin t_valid = c; first_in = layer_in; end
      if (done) begin t_done = c; break; end
      if (poke == 1 && c == 3) begin
        load_we = 1'b1; load_addr = '0; load_in = mk_in(9); load_expected = mk_exp(9);
        start = 1'b1;
      end
      if (poke == 1 && c == 4) begin load_we = 1'b0; start = 1'b0; end
      @(negedge clk);
    end
    load_we = 1'b0; start = 1'b0;
    if (t_done < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: done not seen within %0d cycles (n=%0d)", budget, n);
    end
    tick(2);
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(3);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0) begin n_bad++;
      $display("FAIL reset_status: busy=%b done=%b conv=%b want 0 0 0", busy, done, converged); end
    n_cmp++; if (layer_valid !== 1'b0 || layer_learn !== 1'b0) begin n_bad++;
      $display("FAIL reset_strobes: valid=%b learn=%b want 0 0", layer_valid, layer_learn); end
    n_cmp++; if (epoch_count !== 8'd0 || err_count !== '0) begin n_bad++;
      $display("FAIL reset_counts: epoch=%0d err=%0d want 0 0", epoch_count, err_count); end
    n_cmp++; if (layer_in !== '0 || layer_expected !== '0) begin n_bad++;
      $display("FAIL reset_vectors: in=%h exp=%h want 0", layer_in, layer_expected); end
    reset = 1'b0; tick(1);
  endtask

  task automatic test_perfect;
    int tv, td, v0, l0; vin_t fi;
    mode = M_ECHO; v0 = valid_cnt; l0 = learn_cnt;
    run_a(2, 200, 0, tv, td, fi);
    n_cmp++; if (td - tv !== 11) begin n_bad++;
      $display("FAIL perfect_latency: valid->done %0d cycles want 11", td - tv); end
    n_cmp++; if (fi !== mk_in(0)) begin n_bad++;
      $display("FAIL perfect_first_in: got %h want %h", fi, mk_in(0)); end
    n_cmp++; if (valid_cnt - v0 !== 2 || learn_cnt - l0 !== 0) begin n_bad++;
      $display("FAIL perfect_pulses: valid=%0d learn=%0d want 2 0", valid_cnt - v0, learn_cnt - l0); end
    n_cmp++; if (converged !== 1'b1 || epoch_count !== 8'd1 || err_count !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL perfect_status: conv=%b epoch=%0d err=%0d busy=%b want 1 1 0 0",
                        converged, epoch_count, err_count, busy); end
    n_cmp++; if (layer_in !== mk_in(1) || layer_expected !== mk_exp(1)) begin n_bad++;
      $display("FAIL perfect_hold_last: in=%h want %h", layer_in, mk_in(1)); end
  endtask

  task automatic test_num_samples;
    int tv, td, v0; vin_t fi;
    mode = M_ECHO; v0 = valid_cnt;
    run_a(0, 50, 0, tv, td, fi);
    n_cmp++; if (td !== 1) begin n_bad++;
      $display("FAIL n0_done_time: done at cycle %0d after start edge want 1", td); end
    n_cmp++; if (valid_cnt - v0 !== 0 || converged !== 1'b1 || epoch_count !== 8'd0) begin n_bad++;
      $display("FAIL n0_status: valid=%0d conv=%b epoch=%0d want 0 1 0",
               valid_cnt - v0, converged, epoch_count); end
    v0 = valid_cnt;
    run_a(DEPTH + 3, 300, 0, tv, td, fi);
    n_cmp++; if (valid_cnt - v0 !== DEPTH) begin n_bad++;
      $display("FAIL nclamp_pulses: valid=%0d want %0d", valid_cnt - v0, DEPTH); end
    n_cmp++; if (td - tv !== 41 || layer_in !== mk_in(DEPTH - 1)) begin n_bad++;
      $display("FAIL nclamp_run: latency=%0d want 41, last in=%h want %h",
               td - tv, layer_in, mk_in(DEPTH - 1)); end
  endtask

  task automatic test_busy_ignore;
    int tv, td, v0; vin_t fi;
    mode = M_ECHO; v0 = valid_cnt;
    run_a(2, 200, 1, tv, td, fi);
    tick(3);
    n_cmp++; if (td - tv !== 11 || valid_cnt - v0 !== 2 || epoch_count !== 8'd1 || done !== 1'b1) begin
      n_bad++; $display("FAIL busy_run: latency=%0d valid=%0d epoch=%0d done=%b want 11 2 1 1",
                        td - tv, valid_cnt - v0, epoch_count, done); end
    run_a(1, 100, 0, tv, td, fi);
    n_cmp++; if (fi !== mk_in(0) || layer_expected !== mk_exp(0)) begin n_bad++;
      $display("FAIL busy_mem: in=%h want %h", fi, mk_in(0)); end
  endtask

  task automatic test_load_with_start;
    int tv, td; vin_t fi;
    mode = M_ECHO;
    run_a(1, 100, 2, tv, td, fi);
    n_cmp++; if (fi !== mk_in(9) || layer_expected !== mk_exp(9)) begin n_bad++;
      $display("FAIL load_start: in=%h want %h", fi, mk_in(9)); end
    load_a(0, mk_in(0), mk_exp(0));
  endtask

  task automatic test_converge3;
    int tv, td, v0; vin_t fi;
    mode = M_CONV3; learn_base = learn_cnt; v0 = valid_cnt;
    run_a(2, 400, 0, tv, td, fi);
    n_cmp++; if (converged !== 1'b1 || epoch_count !== 8'd4 || err_count !== '0) begin n_bad++;
      $display("FAIL conv3_status: conv=%b epoch=%0d err=%0d want 1 4 0",
               converged, epoch_count, err_count); end
    n_cmp++; if (learn_cnt - learn_base !== 6 || valid_cnt - v0 !== 14) begin n_bad++;
      $display("FAIL conv3_pulses: learn=%0d valid=%0d want 6 14",
               learn_cnt - learn_base, valid_cnt - v0); end
  endtask

  task automatic test_reset_during_learn;
    int tv, td, vr, c; vin_t fi;
    mode = M_ZERO;
    num_samples = NW'(2); start = 1'b1; @(negedge clk); start = 1'b0;
    for (c = 0; c < 50; c++) begin
      if (layer_learn) break;
      @(negedge clk);
    end
    n_cmp++; if (layer_learn !== 1'b1) begin n_bad++;
      $display("FAIL rst_learn_seen: learn=%b after %0d cycles want 1", layer_learn, c); end
    reset = 1'b1; @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || layer_valid !== 1'b0 || layer_learn !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL rst_midrun: busy=%b valid=%b learn=%b done=%b want 0 0 0 0",
                        busy, layer_valid, layer_learn, done); end
    vr = valid_cnt;
    tick(2); reset = 1'b0; tick(4);
    n_cmp++; if (valid_cnt !== vr || busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_quiet: extra valid=%0d busy=%b want 0 0", valid_cnt - vr, busy); end
    mode = M_ECHO;
    run_a(2, 200, 0, tv, td, fi);
    n_cmp++; if (fi !== mk_in(0) || layer_expected !== mk_exp(1) || converged !== 1'b1) begin n_bad++;
      $display("FAIL rst_mem_intact: first in=%h want %h conv=%b", fi, mk_in(0), converged); end
  endtask

  task automatic test_no_converge;
    int tv, td, v0, l0; vin_t fi;
    load_a(0, mk_in(0), fill_out(8'hFF));
    load_a(1, mk_in(1), fill_out(8'hFF));
    mode = M_ZERO; v0 = valid_cnt; l0 = learn_cnt;
    run_a(2, 6000, 0, tv, td, fi);
    n_cmp++; if (converged !== 1'b0 || epoch_count !== 8'd255) begin n_bad++;
      $display("FAIL noconv_status: conv=%b epoch=%0d want 0 255", converged, epoch_count); end
    n_cmp++; if (err_count !== EW'(2 * N_OUT)) begin n_bad++;
      $display("FAIL noconv_err: err=%0d want %0d", err_count, 2 * N_OUT); end
    n_cmp++; if (learn_cnt - l0 !== 510 || valid_cnt - v0 !== 1020) begin n_bad++;
      $display("FAIL noconv_pulses: learn=%0d valid=%0d want 510 1020",
               learn_cnt - l0, valid_cnt - v0); end
  endtask

  task automatic test_tol;
    int td;
    vout_t off;
    load_we_b = 1'b1; load_addr_b = '0; load_in_b = mk_in(0); load_expected_b = fill_out(8'h40);
    @(negedge clk); load_we_b = 1'b0;
    // Every output one LSB high: inside the window.
    off_b = fill_out(8'h01);
    num_samples_b = NW'(1); start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    td = -1;
    for (int c = 0; c < 200; c++) begin
      if (done_b) begin td = c; break; end
      @(negedge clk);
    end
    n_cmp++; if (td < 0 || converged_b !== 1'b1 || err_count_b !== '0 || epoch_count_b !== 8'd1) begin
      n_bad++; $display("FAIL tol_off1: done_at=%0d conv=%b err=%0d epoch=%0d want conv 1 err 0 epoch 1",
                        td, converged_b, err_count_b, epoch_count_b); end
    // Five outputs +2, five outputs -2, the rest -1: ten outside the window.
    off = fill_out(8'hFF);
    for (int j = 0; j < 5; j++) off[j] = 8'h02;
    for (int j = 5; j < 10; j++) off[j] = 8'hFE;
    off_b = off;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    td = -1;
    for (int c = 0; c < 200; c++) begin
      if (done_b) begin td = c; break; end
      @(negedge clk);
    end
    n_cmp++; if (td < 0 || converged_b !== 1'b0 || epoch_count_b !== 8'd3) begin n_bad++;
      $display("FAIL tol_limit: done_at=%0d conv=%b epoch=%0d want conv 0 epoch 3",
               td, converged_b, epoch_count_b); end
    n_cmp++; if (err_count_b !== EW'(10)) begin n_bad++;
      $display("FAIL tol_off2: err=%0d want 10", err_count_b); end
  endtask

  task automatic test_pulse_rules;
    n_cmp++; if (consec_cnt !== 0 || stray_cnt !== 0) begin n_bad++;
      $display("FAIL pulse_rules: back-to-back valid=%0d learn-without-valid=%0d want 0 0",
               consec_cnt, stray_cnt); end
  endtask

  initial begin
    test_reset;
    for (int k = 0; k < DEPTH; k++) load_a(k, mk_in(k), mk_exp(k));
    test_perfect;
    test_num_samples;
    test_busy_ignore;
    test_load_with_start;
    test_converge3;
    test_reset_during_learn;
    test_no_converge;
    test_tol;
    test_pulse_rules;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
